// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction issuer: default word width and
// the issue FSM state encoding.
package cpu_pkg;

  localparam int DEFAULT_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrapping pointers and an explicit occupancy count.
// A push while full is dropped; a pop while empty is ignored.
module sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rptr_q];
  assign count_o    = count_q;

  // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: queues instruction words and hands them one at a time
// to a CPU with a single-cycle Run strobe, waiting for done (with timeout).
module instr_issuer
  import cpu_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [DW-1:0]          dataIn_o,
  output logic                   Run_o,
  input  logic                   done_i,
  output logic                   busy,
  output logic                   overflow,
  output logic                   timeout_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  logic [TW-1:0] wait_cnt_q;
  logic [DW-1:0] data_q;
  logic          run_q;
  logic          busy_q;
  logic          ovf_q;
  logic          to_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [DW-1:0] fifo_head;

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (wr_en),
    .push_data_i (wr_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

  assign full        = fifo_full;
  assign dataIn_o    = data_q;
  assign Run_o       = run_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign timeout_err = to_q;

  // Sticky overflow: any write attempt while the queue is full.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf_q <= 1'b0;
    else if (wr_en && fifo_full) ovf_q <= 1'b1;
  end

  // Issue FSM with registered Run/busy; the wait counter indexes WAIT cycles
  // from 0, so the TIMEOUT-th WAIT cycle without done aborts to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      data_q     <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      run_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            data_q  <= fifo_head;
            state_q <= ST_ISSUE;
            run_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q    <= ST_WAIT;
          wait_cnt_q <= '0;
        end
        ST_WAIT: begin
          if (done_i) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            to_q       <= 1'b1;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer against a queue-based reference model.
module tb_instr_issuer;

  localparam int DW      = 16;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 12;

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          done_i = 1'b0;
  logic          full;
  logic [3:0]    count;
  logic [DW-1:0] dataIn_o;
  logic          Run_o;
  logic          busy;
  logic          overflow;
  logic          timeout_err;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            m_phase;
  int            m_waited;
  logic [DW-1:0] m_data;
  logic          m_ovf;
  logic          m_to;

  instr_issuer #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .count       (count),
    .dataIn_o    (dataIn_o),
    .Run_o       (Run_o),
    .done_i      (done_i),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    m_phase  = PH_IDLE;
    m_waited = 0;
    m_data   = '0;
    m_ovf    = 1'b0;
    m_to     = 1'b0;
  endfunction

  // One clock edge of the specified behaviour, given the inputs of that cycle.
  function automatic void model_step(input logic we, input logic [DW-1:0] wd, input logic dn);
    bit was_full = (mq.size() == DEPTH);
    bit popping  = (m_phase == PH_IDLE) && (mq.size() != 0);
    if (we && was_full) m_ovf = 1'b1;
    if (popping) m_data = mq.pop_front();
    if (we && !was_full) mq.push_back(wd);
    case (m_phase)
      PH_IDLE:  if (popping) m_phase = PH_ISSUE;
      PH_ISSUE: begin m_phase = PH_WAIT; m_waited = 0; end
      default: begin
        m_waited++;
        if (dn) m_phase = PH_IDLE;
        else if (m_waited == TIMEOUT) begin m_to = 1'b1; m_phase = PH_IDLE; end
      end
    endcase
  endfunction

  function automatic logic [24:0] exp_vec();
    return {m_phase == PH_ISSUE, m_phase != PH_IDLE, mq.size() == DEPTH,
            m_ovf, m_to, 4'(mq.size()), m_data};
  endfunction

  function automatic logic [24:0] obs_vec();
    return {Run_o, busy, full, overflow, timeout_err, count, dataIn_o};
  endfunction

  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic dn);
    wr_en = we; wr_data = wd; done_i = dn;
    @(posedge clk);
    model_step(we, wd, dn);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; wr_data = '0; done_i = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (obs_vec() !== 25'd0) begin
      errs++; $display("FAIL reset_async got %h want %h", obs_vec(), 25'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL reset_idle c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int since = 100;
    int runs  = 0;
    do_reset();
    cycle(1'b1, 16'h3F1F, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      cycle(1'b0, '0, since == 2);
      if (m_phase == PH_ISSUE) since = 0; else since++;
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL single c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (Run_o === 1'b1) runs++;
      if (m_phase == PH_WAIT) begin
        vecs++;
        if (dataIn_o !== 16'h3F1F) begin
          errs++; $display("FAIL single_hold got %h want 3f1f", dataIn_o);
        end
      end
    end
    vecs++;
    if (runs != 1) begin errs++; $display("FAIL single_runs got %0d want 1", runs); end
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    int            run_at[$];
    logic [DW-1:0] run_dat[$];
    words[0] = 16'h1F1F; words[1] = 16'h3F1F; words[2] = 16'h5F1F;
    do_reset();
    for (int unsigned i = 0; i < 24; i++) begin
      cycle(i < 3, (i < 3) ? words[i] : '0, m_phase == PH_WAIT);
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL b2b c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (Run_o === 1'b1) begin run_at.push_back(int'(i)); run_dat.push_back(dataIn_o); end
    end
    vecs++;
    if (run_at.size() != 3) begin
      errs++; $display("FAIL b2b_pulses got %0d want 3", run_at.size());
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        vecs++;
        if (run_dat[k] !== words[k]) begin
          errs++; $display("FAIL b2b_order k%0d got %h want %h", k, run_dat[k], words[k]);
        end
        if (k > 0) begin
          vecs++;
          if (run_at[k] - run_at[k-1] != 3) begin
            errs++; $display("FAIL b2b_spacing k%0d got %0d want 3", k, run_at[k] - run_at[k-1]);
          end
        end
      end
    end
    vecs++;
    if (count !== 4'd0) begin errs++; $display("FAIL b2b_count got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int unsigned i = 0; i < 9; i++) begin
      cycle(1'b1, 16'hA000 + 16'(i), 1'b0);
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL fill c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vecs++;
    if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0}) begin
      errs++; $display("FAIL fill_full got f%b c%0d o%b want f1 c8 o0", full, count, overflow);
    end
    cycle(1'b1, 16'hDEAD, 1'b0);
    vecs++;
    if ({overflow, count} !== {1'b1, 4'd8}) begin
      errs++; $display("FAIL overflow got o%b c%0d want o1 c8", overflow, count);
    end
    for (int unsigned i = 0; i < 200 && (mq.size() != 0 || m_phase != PH_IDLE); i++) begin
      cycle(1'b0, '0, $urandom_range(0, 3) == 0);
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL drain c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vecs++;
    if (overflow !== 1'b1) begin errs++; $display("FAIL overflow_sticky got %b want 1", overflow); end
  endtask

  task automatic test_timeout();
    int waits = 0;
    do_reset();
    cycle(1'b1, 16'h1234, 1'b0);
    cycle(1'b1, 16'h5678, 1'b0);
    for (int unsigned i = 0; i < 40 && !m_to; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (busy === 1'b1 && Run_o === 1'b0) waits++;
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL timeout c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vecs++;
    if ({timeout_err, busy} !== 2'b10) begin
      errs++; $display("FAIL timeout_flag got to%b busy%b want to1 busy0", timeout_err, busy);
    end
    vecs++;
    if (waits != TIMEOUT) begin errs++; $display("FAIL timeout_len got %0d want %0d", waits, TIMEOUT); end
    cycle(1'b0, '0, 1'b0);
    vecs++;
    if ({Run_o, dataIn_o} !== {1'b1, 16'h5678}) begin
      errs++; $display("FAIL timeout_next got run%b %h want run1 5678", Run_o, dataIn_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    int runs = 0;
    do_reset();
    cycle(1'b1, 16'h0101, 1'b0);
    cycle(1'b1, 16'h0202, 1'b0);
    cycle(1'b1, 16'h0303, 1'b0);
    cycle(1'b0, '0, 1'b0);
    vecs++;
    if ({busy, count} !== {1'b1, 4'd2}) begin
      errs++; $display("FAIL midwait_setup got busy%b c%0d want busy1 c2", busy, count);
    end
    #3 resetn = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (obs_vec() !== 25'd0) begin
      errs++; $display("FAIL midwait_reset got %h want %h", obs_vec(), 25'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (Run_o === 1'b1) runs++;
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL midwait_post c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vecs++;
    if (runs != 0) begin errs++; $display("FAIL midwait_norun got %0d want 0", runs); end
    cycle(1'b1, 16'h0404, 1'b0);
    cycle(1'b0, '0, 1'b0);
    vecs++;
    if ({Run_o, dataIn_o} !== {1'b1, 16'h0404}) begin
      errs++; $display("FAIL midwait_new got run%b %h want run1 0404", Run_o, dataIn_o);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [DW-1:0] next_run = '0;
    int            seen = 0;
    do_reset();
    cycle(1'b1, 16'hAAAA, 1'b0);
    cycle(1'b1, 16'hBBBB, 1'b0);
    vecs++;
    if ({count, Run_o, dataIn_o} !== {4'd1, 1'b1, 16'hAAAA}) begin
      errs++; $display("FAIL simul_count got c%0d run%b %h want c1 run1 aaaa", count, Run_o, dataIn_o);
    end
    for (int unsigned i = 0; i < 10; i++) begin
      cycle(1'b0, '0, m_phase == PH_WAIT);
      if (Run_o === 1'b1 && seen == 0) begin seen = 1; next_run = dataIn_o; end
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL simul c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vecs++;
    if (next_run !== 16'hBBBB) begin errs++; $display("FAIL simul_next got %h want bbbb", next_run); end
  endtask

  task automatic test_random();
    do_reset();
    for (int unsigned i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 2) == 0, DW'($urandom), $urandom_range(0, 3) == 0);
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++; $display("FAIL random c%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_mid_wait();
    test_simul_push_pop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
